// File: rtl/ieee_to_fixed_sampler.sv
// rtl/ieee_to_fixed_sampler.sv - IEEE-754 single to saturating signed fixed point via a serial shifter; ROUND_NEAREST_EN selects round-half-away over truncation
module ieee_to_fixed_sampler #(
  parameter int INT_LEN = 16,
  parameter int FRA_LEN = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick,
  input  logic [31:0]                ieee_in,
  output logic [INT_LEN+FRA_LEN:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       ovf_flag,
  output logic                       nan_flag,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);

  localparam int W    = INT_LEN + FRA_LEN + 1;
  localparam int MAGW = ((INT_LEN + FRA_LEN) > 24 ? (INT_LEN + FRA_LEN) : 24) + 1;
  localparam logic [MAGW-1:0] MAG_MAX = {{(MAGW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [W-1:0]    SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    SAT_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SHIFT  = 3'd2,
    S_ROUND  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic            tick_q;
  logic            rise;
  logic [31:0]     cap_q, cap_d;
  logic [MAGW-1:0] mag_q, mag_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            sat_q, sat_d;
  logic            nan_q, nan_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            ovf_flag_q, ovf_flag_d;
  logic            nan_flag_q, nan_flag_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [MAGW-1:0] rnd_mag;
`ifdef ROUND_NEAREST_EN
  logic            guard_q, guard_d;
`endif

  logic [7:0]  dec_exp;
  logic [22:0] dec_mant;
  int          dec_e;
  int          dec_s;
  logic        dec_nan;
  logic        dec_sat;
  logic        dec_norm;
  logic [7:0]  dec_cnt;

  assign rise      = sample_tick & ~tick_q;
  assign out_data  = out_data_q;
  assign ovf_flag  = ovf_flag_q;
  assign nan_flag  = nan_flag_q;
  assign drop_cnt  = drop_cnt_q;

  // Classify the captured float; shortcut results (NaN, saturate, zero) still pass
  // through ROUND so every result obeys the same two-cycle minimum latency.
  always_comb begin
    dec_exp  = cap_q[30:23];
    dec_mant = cap_q[22:0];
    dec_e    = $signed({24'd0, dec_exp}) - 127;
    dec_s    = dec_e + FRA_LEN - 23;
    dec_nan  = 1'b0;
    dec_sat  = 1'b0;
    dec_norm = 1'b0;
    if (dec_exp == 8'hFF) begin
      if (dec_mant != 23'd0) dec_nan = 1'b1;
      else                   dec_sat = 1'b1;
    end else if (dec_exp == 8'h00) begin
      dec_norm = 1'b0;
    end else if (dec_e >= INT_LEN) begin
      dec_sat = 1'b1;
    end else if (dec_e >= -(FRA_LEN + 1)) begin
      dec_norm = 1'b1;
    end
    dec_cnt = 8'((dec_s < 0) ? -dec_s : dec_s);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (rise) state_d = S_DECODE;
      S_DECODE: state_d = (dec_norm && dec_cnt != 8'd0) ? S_SHIFT : S_ROUND;
      S_SHIFT:  if (cnt_q == 8'd1) state_d = S_ROUND;
      S_ROUND:  state_d = S_HOLD;
      S_HOLD:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_valid = (state_q == S_HOLD);
    busy      = (state_q == S_DECODE) || (state_q == S_SHIFT) || (state_q == S_ROUND);
  end

  // Datapath: capture, serial shift, rounding, result/flag update and drop counting
  always_comb begin
    cap_d      = cap_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    sat_d      = sat_q;
    nan_d      = nan_q;
    out_data_d = out_data_q;
    ovf_flag_d = ovf_flag_q;
    nan_flag_d = nan_flag_q;
    drop_cnt_d = drop_cnt_q;
`ifdef ROUND_NEAREST_EN
    guard_d    = guard_q;
    rnd_mag    = mag_q + {{(MAGW-1){1'b0}}, guard_q};
`else
    rnd_mag    = mag_q;
`endif

    if (rise && state_q != S_IDLE && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (rise) cap_d = ieee_in;
      end
      S_DECODE: begin
        sat_d  = dec_sat;
        nan_d  = dec_nan;
        left_d = (dec_s > 0);
        cnt_d  = dec_norm ? dec_cnt : 8'd0;
        mag_d  = dec_norm ? {{(MAGW-24){1'b0}}, 1'b1, dec_mant} : '0;
`ifdef ROUND_NEAREST_EN
        guard_d = 1'b0;
`endif
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 8'd1;
        if (left_q) begin
          mag_d = {mag_q[MAGW-2:0], 1'b0};
        end else begin
          mag_d = {1'b0, mag_q[MAGW-1:1]};
`ifdef ROUND_NEAREST_EN
          guard_d = mag_q[0];
`endif
        end
      end
      S_ROUND: begin
        ovf_flag_d = 1'b0;
        nan_flag_d = 1'b0;
        if (nan_q) begin
          out_data_d = '0;
          nan_flag_d = 1'b1;
        end else if (sat_q || rnd_mag > MAG_MAX) begin
          out_data_d = cap_q[31] ? SAT_NEG : SAT_POS;
          ovf_flag_d = 1'b1;
        end else begin
          out_data_d = cap_q[31] ? -rnd_mag[W-1:0] : rnd_mag[W-1:0];
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          ovf_flag_d = 1'b0;
          nan_flag_d = 1'b0;
        end
      end
      default: begin
        cap_d = cap_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q     <= 1'b0;
      cap_q      <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      left_q     <= 1'b0;
      sat_q      <= 1'b0;
      nan_q      <= 1'b0;
      out_data_q <= '0;
      ovf_flag_q <= 1'b0;
      nan_flag_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef ROUND_NEAREST_EN
      guard_q    <= 1'b0;
`endif
    end else begin
      tick_q     <= sample_tick;
      cap_q      <= cap_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      sat_q      <= sat_d;
      nan_q      <= nan_d;
      out_data_q <= out_data_d;
      ovf_flag_q <= ovf_flag_d;
      nan_flag_q <= nan_flag_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef ROUND_NEAREST_EN
      guard_q    <= guard_d;
`endif
    end
  end

endmodule

// File: tb/tb_ieee_to_fixed_sampler.sv
// tb/tb_ieee_to_fixed_sampler.sv - scoreboard bench for ieee_to_fixed_sampler (default parameters)
module tb_ieee_to_fixed_sampler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [31:0] ieee_in = 32'd0;
  logic        out_ready = 1'b1;
  logic [24:0] out_data;
  logic        out_valid;
  logic        ovf_flag;
  logic        nan_flag;
  logic        busy;
  logic [7:0]  drop_cnt;

  ieee_to_fixed_sampler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .ieee_in     (ieee_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ovf_flag    (ovf_flag),
    .nan_flag    (nan_flag),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ROUND_NEAREST_EN
  localparam logic [24:0] HALF_LSB_EXP    = 25'h0000001;
  localparam logic [24:0] ONEHALF_LSB_EXP = 25'h0000002;
`else
  localparam logic [24:0] HALF_LSB_EXP    = 25'h0000000;
  localparam logic [24:0] ONEHALF_LSB_EXP = 25'h0000001;
`endif

  typedef struct {
    logic [24:0] data;
    logic        ovf;
    logic        nan;
    int          lat;
    int          cap;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, want);
  endtask

  // Monitor: each new result is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        chk("unexpected result", {7'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        m_e = sb.pop_front();
        chk({m_e.nm, " data"}, {7'd0, out_data}, {7'd0, m_e.data});
        chk({m_e.nm, " flags"}, {30'd0, ovf_flag, nan_flag}, {30'd0, m_e.ovf, m_e.nan});
        chk({m_e.nm, " latency"}, cyc - m_e.cap, m_e.lat);
      end
    end
    prev_v <= out_valid;
  end

  task automatic drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " drain"}, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] f, input logic [24:0] d, input logic ovf,
                      input logic nan, input int lat, input string nm, input bit wait_done);
    exp_t e;
    @(negedge clk);
    ieee_in = f;
    sample_tick = 1'b1;
    e.data = d; e.ovf = ovf; e.nan = nan; e.lat = lat; e.cap = cyc + 1; e.nm = nm;
    sb.push_back(e);
    repeat (3) @(negedge clk);
    sample_tick = 1'b0;
    if (wait_done) drain(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset out_data", {7'd0, out_data}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset flags", {30'd0, ovf_flag, nan_flag}, 32'd0);
    chk("reset drop_cnt", {24'd0, drop_cnt}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    send(32'h40200000, 25'h0000280, 1'b0, 1'b0, 16, "pos 2.5",      1'b1);
    send(32'hC0200000, 25'h1FFFD80, 1'b0, 1'b0, 16, "neg 2.5",      1'b1);
    send(32'h3F800000, 25'h0000100, 1'b0, 1'b0, 17, "one",          1'b1);
    send(32'h3B000000, HALF_LSB_EXP, 1'b0, 1'b0, 26, "half lsb",    1'b1);
    send(32'h3B800000, 25'h0000001, 1'b0, 1'b0, 25, "one lsb",      1'b1);
    send(32'h3BC00000, ONEHALF_LSB_EXP, 1'b0, 1'b0, 25, "1.5 lsb",  1'b1);
    send(32'h477FFF00, 25'h0FFFF00, 1'b0, 1'b0, 2,  "65535",        1'b1);
    send(32'h3A800000, 25'h0000000, 1'b0, 1'b0, 2,  "underflow",    1'b1);
    send(32'h00000000, 25'h0000000, 1'b0, 1'b0, 2,  "zero",         1'b1);
    send(32'h80000000, 25'h0000000, 1'b0, 1'b0, 2,  "neg zero",     1'b1);
    send(32'h47800000, 25'h0FFFFFF, 1'b1, 1'b0, 2,  "sat pos",      1'b1);
    send(32'hC7800000, 25'h1000000, 1'b1, 1'b0, 2,  "sat neg",      1'b1);
    send(32'h7F800000, 25'h0FFFFFF, 1'b1, 1'b0, 2,  "inf",          1'b1);
    send(32'hFF800000, 25'h1000000, 1'b1, 1'b0, 2,  "neg inf",      1'b1);
    send(32'h7FC00000, 25'h0000000, 1'b0, 1'b1, 2,  "nan",          1'b1);
    send(32'hFF800001, 25'h0000000, 1'b0, 1'b1, 2,  "neg nan",      1'b1);

    // Backpressure: second tick while a result is held must be dropped
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h40200000, 25'h0000280, 1'b0, 1'b0, 16, "bp first", 1'b0);
    drain("bp first");
    @(negedge clk);
    ieee_in = 32'h3F800000;
    sample_tick = 1'b1;
    repeat (3) @(negedge clk);
    sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("bp held valid", {31'd0, out_valid}, 32'd1);
    chk("bp held data", {7'd0, out_data}, 32'h0000280);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp released valid", {31'd0, out_valid}, 32'd0);
    chk("bp released flags", {30'd0, ovf_flag, nan_flag}, 32'd0);
    out_ready = 1'b1;
    send(32'hC0200000, 25'h1FFFD80, 1'b0, 1'b0, 16, "bp next", 1'b1);
    chk("bp drop_cnt kept", {24'd0, drop_cnt}, 32'd1);

    // Reset in the middle of SHIFT
    send(32'h40200000, 25'h0000280, 1'b0, 1'b0, 16, "aborted", 1'b0);
    repeat (3) @(negedge clk);
    chk("mid busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst out_data", {7'd0, out_data}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst flags", {30'd0, ovf_flag, nan_flag}, 32'd0);
    chk("rst drop_cnt", {24'd0, drop_cnt}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send(32'h3F800000, 25'h0000100, 1'b0, 1'b0, 17, "after reset", 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ieee_to_fixed_sampler.md
# ieee_to_fixed_sampler

Downstream consumer of the op-amp model's 32-bit IEEE-754 `square_out` word. On each rising edge of the model's sample tick it captures the float and converts it to signed two's-complement fixed point. The conversion is a serial, one-bit-per-cycle shift engine with saturation and NaN handling. The result is presented on a valid/ready port to the capture/logging stage.

## Interface
- `INT_LEN`, default 16: integer bits of the result, excluding sign.
- `FRA_LEN`, default 8: fraction bits of the result.
- Derived `W = INT_LEN+FRA_LEN+1`: result width.
- `clk`  in  1: system clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sample_tick`  in  1: upstream `clk_100k`, generated in the `clk` domain; only its rising edge is used.
- `ieee_in`  in  32: IEEE-754 single, sampled on a detected tick rise.
- `out_data`  out  W: fixed-point result; reset 0.
- `out_valid`  out  1: result available; reset 0.
- `out_ready`  in  1: consumer accepts the result.
- `ovf_flag`  out  1: result saturated; reset 0; valid with `out_valid`.
- `nan_flag`  out  1: input was NaN; reset 0; valid with `out_valid`.
- `busy`  out  1: conversion in progress; reset 0.
- `drop_cnt`  out  8: saturating count of ticks dropped; reset 0.

## Operation
- Tick detection:
  - `tick_d <= sample_tick`, reset 0.
  - `rise = sample_tick & ~tick_d`.
- FSM states: IDLE, DECODE, SHIFT, ROUND, HOLD. Reset state is IDLE.
- IDLE:
  - On `rise`, latch `ieee_in` into `cap`, then go to DECODE.
- DECODE: unbiased exponent `e = exp-127`. Resolve in priority order:
  - exp=255 and mant≠0 → NaN: `out_data`=0, `nan_flag`=1, go to HOLD.
  - exp=255 and mant=0 (inf) → saturate, go to HOLD.
  - exp=0 (zero, denormal, -0) → `out_data`=0, go to HOLD.
  - e ≥ INT_LEN → saturate, go to HOLD.
  - e < -(FRA_LEN+1) → `out_data`=0, go to HOLD.
  - Otherwise:
    - Load `mag = {1,mant}` into a register of width max(24, INT_LEN+FRA_LEN)+1.
    - Set `s = e+FRA_LEN-23` and `cnt = |s|`.
    - Clear `guard`.
    - Go to SHIFT, or to ROUND if `cnt`=0.
- SHIFT: one bit per cycle until `cnt` reaches 0, then go to ROUND.
  - If `s` > 0: shift `mag` left.
  - If `s` < 0: shift `mag` right, and `guard` takes the bit shifted out.
- ROUND:
  - Add the rounding increment (see Configuration).
  - If `mag` exceeds 2^(W-1)-1, saturate.
  - Otherwise `out_data` = sign ? -mag : mag.
  - Go to HOLD.
- Saturation: `out_data` = sign ? -2^(W-1) : 2^(W-1)-1, and `ovf_flag`=1.
  - With the defaults, 0x1000000 or 0x0FFFFFF.
- HOLD:
  - `out_valid`=1; `out_data` and flags stay stable.
  - When `out_valid & out_ready`, go to IDLE and clear the flags.
- `busy` = 1 in DECODE, SHIFT and ROUND.
- A `rise` in any state other than IDLE drops that sample:
  - `drop_cnt` increments, saturating at 255.
  - The in-flight or held result is unaffected.
- A `rise` in the same cycle HOLD returns to IDLE is also dropped; IDLE must be reached first.
- Reset mid-operation clears everything immediately and does not emit a partial result.

## Timing
- Capture edge: the `clk` edge on which `rise` is high.
- `out_valid` rises at capture + 2 + |s| cycles when the value goes through SHIFT/ROUND.
- `out_valid` rises at capture + 2 cycles for every DECODE shortcut.
- Worst-case right shift is 24 cycles, so latency is at most 26 cycles.
  - This is far below the 1000-cycle tick period, so no drops occur while the consumer keeps `out_ready` high.
- `out_data` changes only on entry to HOLD.
- The acceptance handshake itself adds no extra cycle.

## Configuration
- `ROUND_NEAREST_EN` defined:
  - In ROUND, add `guard` to `mag`: round half away from zero on magnitude.
  - A carry that pushes `mag` past the maximum saturates and sets `ovf_flag`.
- Not defined:
  - Truncate toward zero: `guard` is ignored.
  - The ROUND state still takes one cycle, so latency is identical in both builds.

## Test plan
All scenarios use the defaults (INT_LEN=16, FRA_LEN=8).

- Positive value: tick with `ieee_in`=0x40200000 (2.5) → `out_data`=0x0000280 at capture+16 cycles; flags 0.
- Negative value: 0xC0200000 (-2.5) → `out_data`=0x1FFFD80.
- Rounding of an exact half LSB: 0x3B000000 (2^-9).
  - With `ROUND_NEAREST_EN` → 0x0000001.
  - Without → 0x0000000.
  - 0x3B800000 (2^-8) → 0x0000001 in both builds.
- Saturation and NaN, each at capture+2 cycles:
  - 0x47800000 (65536) → 0x0FFFFFF with `ovf_flag`=1.
  - 0xC7800000 → 0x1000000 with `ovf_flag`=1.
  - 0x7FC00000 → 0 with `nan_flag`=1.
- Backpressure: hold `out_ready`=0 across two ticks.
  - First result is held stable.
  - `drop_cnt`=1.
  - After `out_ready`=1 for one cycle, `out_valid`=0 and the next tick converts normally.
- Reset during SHIFT: assert `reset_n`=0 mid-conversion → all outputs 0 at once; the first tick after release converts correctly.
